// File: rtl/frame_buffer.sv
// rtl/frame_buffer.sv - double-buffered 64x64 RGB888 frame store feeding the HUB75 driver
// Optional build macro: FRAME_BUFFER_CLEAR_EN (zero all memories after reset before accepting pixels)
module frame_buffer #(
    parameter int HORIZONTAL_LENGTH = 64,
    parameter int VERTICAL_LENGTH   = 32,
    parameter int ADDR_WIDTH        = 11,
    parameter int DATA_WIDTH        = 24
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_wr_last,
    input  logic                  i_frame_done,
    input  logic [ADDR_WIDTH-1:0] i_rd_address,
    output logic [DATA_WIDTH-1:0] o_data0,
    output logic [DATA_WIDTH-1:0] o_data1,
    output logic                  o_front_sel,
    output logic                  o_swap_pending,
    output logic                  o_frame_err
);

    localparam int HALF_WORDS  = HORIZONTAL_LENGTH * VERTICAL_LENGTH;
    localparam int FRAME_WORDS = 2 * HALF_WORDS;
    localparam int PTR_W       = $clog2(FRAME_WORDS);

    typedef enum logic [1:0] {
        ST_WRITE     = 2'd0,
        ST_WAIT_SWAP = 2'd1
`ifdef FRAME_BUFFER_CLEAR_EN
        ,
        ST_CLEAR     = 2'd2
`endif
    } state_t;

    state_t                state_q;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic                  wr_ready_q;
    logic                  front_sel_q;
    logic                  swap_pending_q;
    logic                  frame_err_q;
    logic [DATA_WIDTH-1:0] data0_q;
    logic [DATA_WIDTH-1:0] data1_q;
`ifdef FRAME_BUFFER_CLEAR_EN
    logic [ADDR_WIDTH-1:0] clr_ptr_q;
`endif

    // One array per (buffer, half) so each display half reads in parallel.
    logic [DATA_WIDTH-1:0] mem_b0_h0 [HALF_WORDS];
    logic [DATA_WIDTH-1:0] mem_b0_h1 [HALF_WORDS];
    logic [DATA_WIDTH-1:0] mem_b1_h0 [HALF_WORDS];
    logic [DATA_WIDTH-1:0] mem_b1_h1 [HALF_WORDS];

    logic                  wr_fire;
    logic                  wr_half;
    logic                  wr_buf;
    logic                  ptr_at_end;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [PTR_W-1:0]      wr_ptr_d;

    // Split the raster pointer into panel half and in-half address; back buffer is !front.
    always_comb begin
        wr_fire    = i_wr_valid && wr_ready_q;
        wr_half    = (wr_ptr_q >= PTR_W'(HALF_WORDS));
        wr_buf     = ~front_sel_q;
        ptr_at_end = (wr_ptr_q == PTR_W'(FRAME_WORDS - 1));
        wr_addr    = ADDR_WIDTH'(wr_half ? (wr_ptr_q - PTR_W'(HALF_WORDS)) : wr_ptr_q);
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
    end

    // Frame sequencing: pointer, swap handshake, error flag and write-ready.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr_q       <= '0;
            front_sel_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            frame_err_q    <= 1'b0;
`ifdef FRAME_BUFFER_CLEAR_EN
            state_q        <= ST_CLEAR;
            wr_ready_q     <= 1'b0;
            clr_ptr_q      <= '0;
`else
            state_q        <= ST_WRITE;
            wr_ready_q     <= 1'b1;
`endif
        end else begin
            case (state_q)
                ST_WRITE: begin
                    if (wr_fire) begin
                        if (i_wr_last) begin
                            wr_ptr_q <= '0;
                            if (ptr_at_end) begin
                                state_q        <= ST_WAIT_SWAP;
                                swap_pending_q <= 1'b1;
                                wr_ready_q     <= 1'b0;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                        end else if (ptr_at_end) begin
                            // Overlong frame: resynchronise so the next beat is pixel 0.
                            wr_ptr_q    <= '0;
                            frame_err_q <= 1'b1;
                        end else begin
                            wr_ptr_q <= wr_ptr_d;
                        end
                    end
                end
                ST_WAIT_SWAP: begin
                    if (i_frame_done) begin
                        front_sel_q    <= ~front_sel_q;
                        swap_pending_q <= 1'b0;
                        wr_ready_q     <= 1'b1;
                        state_q        <= ST_WRITE;
                    end
                end
`ifdef FRAME_BUFFER_CLEAR_EN
                ST_CLEAR: begin
                    clr_ptr_q <= clr_ptr_q + ADDR_WIDTH'(1);
                    if (clr_ptr_q == ADDR_WIDTH'(HALF_WORDS - 1)) begin
                        state_q    <= ST_WRITE;
                        wr_ready_q <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q    <= ST_WRITE;
                    wr_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Memory write port: clear sweep (if built) or accepted pixels into the back buffer.
    always_ff @(posedge i_clk) begin
`ifdef FRAME_BUFFER_CLEAR_EN
        if (state_q == ST_CLEAR) begin
            mem_b0_h0[clr_ptr_q] <= '0;
            mem_b0_h1[clr_ptr_q] <= '0;
            mem_b1_h0[clr_ptr_q] <= '0;
            mem_b1_h1[clr_ptr_q] <= '0;
        end else
`endif
        if (wr_fire) begin
            case ({wr_buf, wr_half})
                2'b00:   mem_b0_h0[wr_addr] <= i_wr_data;
                2'b01:   mem_b0_h1[wr_addr] <= i_wr_data;
                2'b10:   mem_b1_h0[wr_addr] <= i_wr_data;
                default: mem_b1_h1[wr_addr] <= i_wr_data;
            endcase
        end
    end

    // Registered read of the front buffer; the swap-cycle read still sees the old front.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            data0_q <= '0;
            data1_q <= '0;
`ifdef FRAME_BUFFER_CLEAR_EN
        end else if (state_q == ST_CLEAR) begin
            data0_q <= '0;
            data1_q <= '0;
`endif
        end else if (front_sel_q) begin
            data0_q <= mem_b1_h0[i_rd_address];
            data1_q <= mem_b1_h1[i_rd_address];
        end else begin
            data0_q <= mem_b0_h0[i_rd_address];
            data1_q <= mem_b0_h1[i_rd_address];
        end
    end

    assign o_wr_ready     = wr_ready_q;
    assign o_data0        = data0_q;
    assign o_data1        = data1_q;
    assign o_front_sel    = front_sel_q;
    assign o_swap_pending = swap_pending_q;
    assign o_frame_err    = frame_err_q;

endmodule

// File: tb/tb_frame_buffer.sv
// tb/tb_frame_buffer.sv - directed scoreboard bench for frame_buffer
module tb_frame_buffer;

    localparam int AW = 11;
    localparam int DW = 24;
    localparam int FULL = 4096;
    localparam int HALF = 2048;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_wr_valid;
    logic          o_wr_ready;
    logic [DW-1:0] i_wr_data;
    logic          i_wr_last;
    logic          i_frame_done;
    logic [AW-1:0] i_rd_address;
    logic [DW-1:0] o_data0;
    logic [DW-1:0] o_data1;
    logic          o_front_sel;
    logic          o_swap_pending;
    logic          o_frame_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int            addr;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
    } rd_exp_t;

    rd_exp_t  sb[$];
    logic [7:0] exp_seed;

    frame_buffer dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_wr_valid     (i_wr_valid),
        .o_wr_ready     (o_wr_ready),
        .i_wr_data      (i_wr_data),
        .i_wr_last      (i_wr_last),
        .i_frame_done   (i_frame_done),
        .i_rd_address   (i_rd_address),
        .o_data0        (o_data0),
        .o_data1        (o_data1),
        .o_front_sel    (o_front_sel),
        .o_swap_pending (o_swap_pending),
        .o_frame_err    (o_frame_err)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [DW-1:0] pix(input logic [7:0] seed, input int idx);
        return {seed, 16'(idx)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic issue_read(input int addr);
        rd_exp_t e;
        i_rd_address = AW'(addr);
        e.addr = addr;
        e.d0   = pix(exp_seed, addr);
        e.d1   = pix(exp_seed, addr + HALF);
        sb.push_back(e);
    endtask

    task automatic collect();
        rd_exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk($sformatf("rd_d0@%0d", e.addr), {8'h0, o_data0}, {8'h0, e.d0});
            chk($sformatf("rd_d1@%0d", e.addr), {8'h0, o_data1}, {8'h0, e.d1});
        end
    endtask

    task automatic rd(input int addr);
        issue_read(addr);
        step();
        collect();
    endtask

    task automatic pulse_done();
        i_frame_done = 1'b1;
        step();
        i_frame_done = 1'b0;
    endtask

    // Writes n beats of {seed, index}; last asserted on beat last_at (-1 = never).
    task automatic write_frame(input logic [7:0] seed, input int n, input int last_at, input bit done_on_last);
        int budget;
        for (int i = 0; i < n; i++) begin
            budget = 0;
            while (!o_wr_ready && budget < 5000) begin
                step();
                budget++;
            end
            if (!o_wr_ready) begin
                chk("wr_ready_timeout", 32'd0, 32'd1);
                i_wr_valid = 1'b0;
                return;
            end
            i_wr_valid   = 1'b1;
            i_wr_data    = pix(seed, i);
            i_wr_last    = (i == last_at);
            i_frame_done = done_on_last && (i == last_at);
            step();
        end
        i_wr_valid   = 1'b0;
        i_wr_last    = 1'b0;
        i_frame_done = 1'b0;
    endtask

    initial begin
        int cnt;
        i_reset      = 1'b0;
        i_wr_valid   = 1'b0;
        i_wr_data    = '0;
        i_wr_last    = 1'b0;
        i_frame_done = 1'b0;
        i_rd_address = '0;
        exp_seed     = 8'h00;
        repeat (3) @(negedge i_clk);
        i_reset = 1'b1;

        // Reset state
        chk("rst_front_sel", {31'd0, o_front_sel}, 32'd0);
        chk("rst_swap_pending", {31'd0, o_swap_pending}, 32'd0);
        chk("rst_frame_err", {31'd0, o_frame_err}, 32'd0);
        chk("rst_data0", {8'h0, o_data0}, 32'd0);
        chk("rst_data1", {8'h0, o_data1}, 32'd0);
`ifdef FRAME_BUFFER_CLEAR_EN
        chk("rst_wr_ready", {31'd0, o_wr_ready}, 32'd0);
        cnt = 0;
        while (!o_wr_ready && cnt < 5000) begin
            step();
            cnt++;
        end
        chk("clear_cycles", cnt, 32'd2048);
`else
        chk("rst_wr_ready", {31'd0, o_wr_ready}, 32'd1);
`endif

        // Full frame of pixel indices, then swap
        write_frame(8'h00, FULL, FULL - 1, 1'b0);
        chk("f0_pending", {31'd0, o_swap_pending}, 32'd1);
        chk("f0_ready_low", {31'd0, o_wr_ready}, 32'd0);
        chk("f0_front_before", {31'd0, o_front_sel}, 32'd0);
        pulse_done();
        chk("f0_front_after", {31'd0, o_front_sel}, 32'd1);
        chk("f0_pending_clr", {31'd0, o_swap_pending}, 32'd0);
        chk("f0_ready_high", {31'd0, o_wr_ready}, 32'd1);
        exp_seed = 8'h00;
        rd(65);
        rd(0);
        rd(2047);

        // Completed frame held without frame_done; display keeps old buffer
        write_frame(8'h01, FULL, FULL - 1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            repeat (248) step();
            chk("hold_ready", {31'd0, o_wr_ready}, 32'd0);
            chk("hold_pending", {31'd0, o_swap_pending}, 32'd1);
            rd(100 + k);
        end
        i_frame_done = 1'b1;
        issue_read(5);
        step();
        i_frame_done = 1'b0;
        collect();
        exp_seed = 8'h01;
        rd(5);
        chk("f1_front", {31'd0, o_front_sel}, 32'd0);

        // Short frame: error, no swap, then a good frame swaps normally
        write_frame(8'h02, 101, 100, 1'b0);
        chk("short_err", {31'd0, o_frame_err}, 32'd1);
        chk("short_pending", {31'd0, o_swap_pending}, 32'd0);
        chk("short_ready", {31'd0, o_wr_ready}, 32'd1);
        pulse_done();
        chk("short_no_swap", {31'd0, o_front_sel}, 32'd0);
        rd(65);
        write_frame(8'h03, FULL, FULL - 1, 1'b0);
        chk("f3_pending", {31'd0, o_swap_pending}, 32'd1);
        pulse_done();
        chk("f3_front", {31'd0, o_front_sel}, 32'd1);
        exp_seed = 8'h03;
        rd(65);
        rd(2047);

        // Long frame: wraps without swap, next frame aligns to pixel 0
        write_frame(8'h04, FULL, -1, 1'b0);
        chk("long_pending", {31'd0, o_swap_pending}, 32'd0);
        chk("long_ready", {31'd0, o_wr_ready}, 32'd1);
        chk("long_err", {31'd0, o_frame_err}, 32'd1);
        write_frame(8'h05, FULL, FULL - 1, 1'b0);
        chk("f5_pending", {31'd0, o_swap_pending}, 32'd1);
        pulse_done();
        chk("f5_front", {31'd0, o_front_sel}, 32'd0);
        exp_seed = 8'h05;
        rd(10);

        // frame_done coincident with the accepted last beat is ignored
        write_frame(8'h06, FULL, FULL - 1, 1'b1);
        chk("coinc_pending", {31'd0, o_swap_pending}, 32'd1);
        chk("coinc_front", {31'd0, o_front_sel}, 32'd0);
        repeat (10) step();
        chk("coinc_front_wait", {31'd0, o_front_sel}, 32'd0);
        pulse_done();
        chk("coinc_front_swap", {31'd0, o_front_sel}, 32'd1);
        exp_seed = 8'h06;
        rd(1234);

        // Reset mid-frame, then a fresh frame
        write_frame(8'h07, 2000, -1, 1'b0);
        i_reset = 1'b0;
        #2;
        chk("mrst_front", {31'd0, o_front_sel}, 32'd0);
        chk("mrst_pending", {31'd0, o_swap_pending}, 32'd0);
        chk("mrst_err", {31'd0, o_frame_err}, 32'd0);
        chk("mrst_data0", {8'h0, o_data0}, 32'd0);
`ifdef FRAME_BUFFER_CLEAR_EN
        chk("mrst_ready", {31'd0, o_wr_ready}, 32'd0);
`else
        chk("mrst_ready", {31'd0, o_wr_ready}, 32'd1);
`endif
        #1;
        i_reset = 1'b1;
        @(negedge i_clk);
        write_frame(8'h08, FULL, FULL - 1, 1'b0);
        chk("f8_pending", {31'd0, o_swap_pending}, 32'd1);
        pulse_done();
        chk("f8_front", {31'd0, o_front_sel}, 32'd1);
        exp_seed = 8'h08;
        rd(0);
        rd(2047);

        chk("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
